reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 0, meaning: when 1, address 0 is never emitted.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  begin a dump, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancel an in-progress dump.
REQ-006 SHALL have port first_addr  input  5  first register index of the range, latched at start.
REQ-007 SHALL have port last_addr  input  5  last register index of the range, latched at start.
REQ-008 SHALL have port rd_addr  output  5  drives the register-file read address.
REQ-009 SHALL have port rd_data  input  32  combinational read data for rd_addr, valid in the same cycle.
REQ-010 SHALL have port out_valid  output  1  an output beat is presented.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the beat.
REQ-012 SHALL have port out_index  output  5  register index of the presented beat.
REQ-013 SHALL have port out_data  output  32  register value of the presented beat.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement states IDLE, READ, HOLD and DONE, with all outputs registered.
REQ-017 In IDLE with start=1: latch first/last into cur/end; go to READ, or to DONE if first_addr>last_addr (zero beats).
REQ-018 With SKIP_ZERO=1 and cur=0 at range entry: cur SHALL start at 1; a range of exactly 0..0 SHALL go to DONE with zero beats.
REQ-019 rd_addr SHALL equal cur in every state.
REQ-020 In READ, on the clock edge: out_data<=rd_data, out_index<=cur, out_valid<=1, next state HOLD.
REQ-021 In HOLD, out_valid, out_index and out_data SHALL hold stable until out_valid&&out_ready.
REQ-022 On the handshake in HOLD: clear out_valid; if cur==end go to DONE, else cur<=cur+1 and go to READ.
REQ-023 Each beat SHALL take a minimum of 2 cycles (READ plus one HOLD cycle); 32 beats take at least 64 cycles before DONE.
REQ-024 cur SHALL never wrap: when end=31, the beat for index 31 SHALL be the last beat.
REQ-025 In DONE: done=1 for exactly one cycle, then IDLE; out_valid=0.
REQ-026 start asserted while busy=1 SHALL be ignored; first_addr/last_addr changes while busy SHALL have no effect.
REQ-027 abort=1 in READ, HOLD or DONE SHALL force IDLE next cycle, clear out_valid, and suppress done (a done already high that cycle completes normally).
REQ-028 abort SHALL take priority over a same-cycle handshake; abort in IDLE SHALL be ignored, and abort SHALL win over start.
REQ-029 The block SHALL never drive any register-file write signal.

Reset
REQ-030 rst=1 at a clock edge SHALL set state=IDLE, cur=0, end=0, rd_addr=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0.
REQ-031 rst SHALL override start, abort and handshake in the same cycle; reset mid-dump SHALL produce no further beats and no done.

Verification
REQ-032 Reg r5=0x12345678, r6=0xDEADBEEF, first=5, last=6, out_ready=1, start pulse -> beats (5,0x12345678), (6,0xDEADBEEF), done 1 cycle; DONE reached 5 cycles after start.
REQ-033 first=0, last=31, SKIP_ZERO=0, out_ready=1 -> 32 beats with index 0..31, out_data for index 0 = 0, index 31 is the last beat, no wrap to 0.
REQ-034 out_ready low for 10 cycles during the beat for r3=0xA5A5A5A5 -> out_valid, out_index=3 and out_data=0xA5A5A5A5 stay constant for all 10 cycles; next beat follows after out_ready rises.
REQ-035 first=7, last=3, start pulse -> no out_valid; done pulses exactly once; busy high for 1 cycle.
REQ-036 Abort asserted during the second HOLD of a 0..31 dump (same cycle as out_ready=1) -> beat not counted as complete, out_valid=0 next cycle, IDLE, no done; a new start then works normally.
REQ-037 rst pulse mid-dump with start also high -> all outputs zero next cycle, state IDLE, and start is ignored that cycle.

Source files
------------

// File: rtl/reg_dump.sv
// Register-file dump engine: walks a latched index range and presents
// each register value as a valid/ready output beat.
module reg_dump #(
    parameter int SKIP_ZERO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  first_addr,
    input  logic [4:0]  last_addr,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [4:0]  cur, cur_n;
    logic [4:0]  end_r, end_n;
    logic [4:0]  out_index_n;
    logic [31:0] out_data_n;
    logic        out_valid_n;
    logic        skip;
    logic [4:0]  entry;

    assign rd_addr = cur;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_comb begin
        state_n     = state;
        cur_n       = cur;
        end_n       = end_r;
        out_valid_n = out_valid;
        out_index_n = out_index;
        out_data_n  = out_data;
        skip        = (SKIP_ZERO != 0) && (first_addr == 5'd0);
        entry       = skip ? 5'd1 : first_addr;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    cur_n = entry;
                    end_n = last_addr;
                    // an empty range still reports completion
                    if ((first_addr > last_addr) || (skip && last_addr == 5'd0))
                        state_n = DONE;
                    else
                        state_n = READ;
                end
            end
            READ: begin
                out_data_n  = rd_data;
                out_index_n = cur;
                out_valid_n = 1'b1;
                state_n     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    if (cur == end_r) begin
                        state_n = DONE;
                    end else begin
                        cur_n   = cur + 5'd1;
                        state_n = READ;
                    end
                end
            end
            DONE: begin
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // abort beats any handshake or beat capture in flight
        if (abort && state != IDLE) begin
            state_n     = IDLE;
            cur_n       = cur;
            out_valid_n = 1'b0;
            out_index_n = out_index;
            out_data_n  = out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= 5'd0;
            end_r     <= 5'd0;
            out_valid <= 1'b0;
            out_index <= 5'd0;
            out_data  <= 32'd0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            end_r     <= end_n;
            out_valid <= out_valid_n;
            out_index <= out_index_n;
            out_data  <= out_data_n;
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a beat-queue model per dump plus
// literal timing checks; a second instance covers SKIP_ZERO=1.
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [4:0]  first_addr, last_addr;
    logic [4:0]  rd_addr0, rd_addr1, out_index0, out_index1;
    logic [31:0] rd_data0, rd_data1, out_data0, out_data1;
    logic        out_valid0, out_valid1, busy0, busy1, done0, done1;

    logic [31:0] regs [32];
    logic [4:0]  exp_idx [$];
    logic [31:0] exp_dat [$];

    int checks = 0;
    int errors = 0;
    int u0_beats, done_cnt, u1_beats, u1_done_cnt;
    logic [4:0] u1_first;

    logic        hold_pend = 1'b0;
    logic [4:0]  prev_idx;
    logic [31:0] prev_dat;

    always #5 clk = ~clk;

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    reg_dump #(.SKIP_ZERO(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_index(out_index0), .out_data(out_data0),
        .busy(busy0), .done(done0)
    );

    reg_dump #(.SKIP_ZERO(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_index(out_index1), .out_data(out_data1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: every accepted beat must be the next one in the range
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pend) begin
                chk("hold_valid", {31'd0, out_valid0}, 32'd1);
                chk("hold_index", {27'd0, out_index0}, {27'd0, prev_idx});
                chk("hold_data", out_data0, prev_dat);
            end
            if (out_valid0)
                chk("valid_busy", {31'd0, busy0}, 32'd1);
            if (out_valid0 && out_ready && !abort) begin
                if (exp_idx.size() == 0) begin
                    chk("extra_beat", {27'd0, out_index0}, 32'hffffffff);
                end else begin
                    chk("beat_index", {27'd0, out_index0},
                        {27'd0, exp_idx.pop_front()});
                    chk("beat_data", out_data0, exp_dat.pop_front());
                end
                u0_beats++;
            end
            if (done0) done_cnt++;
            if (out_valid1 && out_ready && !abort) begin
                if (u1_beats == 0) u1_first = out_index1;
                u1_beats++;
            end
            if (done1) u1_done_cnt++;
            hold_pend = out_valid0 && !out_ready && !abort;
            prev_idx  = out_index0;
            prev_dat  = out_data0;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        exp_idx.delete();
        exp_dat.delete();
        for (int i = int'(f); i <= int'(l); i++) begin
            exp_idx.push_back(5'(i));
            exp_dat.push_back(regs[i]);
        end
        u0_beats = 0; done_cnt = 0; u1_beats = 0; u1_done_cnt = 0;
        u1_first = 5'd0;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
    endtask

    // counts cycles from the start edge until each instance signals done
    task automatic run_done(input int bound, input bit poke,
                            output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int n = 1; n <= bound; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (poke && n == 3) begin
                start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
            end
            if (poke && n == 4) start = 1'b0;
            if (done0 && n0 == 0) n0 = n;
            if (done1 && n1 == 0) n1 = n;
            if (n0 != 0 && n1 != 0) break;
        end
        start = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, {31'd0, out_valid0}, 32'd0);
        chk({name, "_index"}, {27'd0, out_index0}, 32'd0);
        chk({name, "_data"}, out_data0, 32'd0);
        chk({name, "_rdaddr"}, {27'd0, rd_addr0}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy0}, 32'd0);
        chk({name, "_done"}, {31'd0, done0}, 32'd0);
    endtask

    initial begin
        int n0, n1, bc, vc, got;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0;
        regs[3] = 32'hA5A5A5A5;
        regs[5] = 32'h12345678;
        regs[6] = 32'hDEADBEEF;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        first_addr = 5'd0; last_addr = 5'd0;
        u0_beats = 0; done_cnt = 0; u1_beats = 0; u1_done_cnt = 0;
        u1_first = 5'd0;
        tick(); tick();
        rst = 1'b0;
        chk_zero("reset");
        chk("reset_u1_busy", {31'd0, busy1}, 32'd0);

        // two beats, start/addr pokes mid-dump must not matter
        start_dump(5'd5, 5'd6);
        run_done(20, 1'b1, n0, n1);
        chk("t1_done_cycle", n0, 5);
        chk("t1_beats", u0_beats, 2);
        chk("t1_left", exp_idx.size(), 0);
        tick(); tick();
        chk("t1_done_once", done_cnt, 1);
        chk("t1_idle", {31'd0, busy0}, 32'd0);

        // full range; skip-zero instance emits 1..31
        start_dump(5'd0, 5'd31);
        run_done(200, 1'b0, n0, n1);
        chk("t2_done_cycle", n0, 65);
        chk("t2_u1_done_cycle", n1, 63);
        chk("t2_beats", u0_beats, 32);
        chk("t2_left", exp_idx.size(), 0);
        chk("t2_u1_beats", u1_beats, 31);
        chk("t2_u1_first", {27'd0, u1_first}, 32'd1);
        tick(); tick();
        chk("t2_done_once", done_cnt, 1);

        // backpressure on the r3 beat
        out_ready = 1'b0;
        start_dump(5'd2, 5'd4);
        got = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            start = 1'b0;
            if (out_valid0) begin got = 1; break; end
        end
        chk("t3_first_seen", got, 1);
        chk("t3_first_idx", {27'd0, out_index0}, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_valid", {31'd0, out_valid0}, 32'd1);
            chk("t3_stall_index", {27'd0, out_index0}, 32'd3);
            chk("t3_stall_data", out_data0, 32'hA5A5A5A5);
            if (i < 9) tick();
        end
        tick();
        out_ready = 1'b1;
        run_done(20, 1'b0, n0, n1);
        chk("t3_beats", u0_beats, 3);
        chk("t3_left", exp_idx.size(), 0);
        tick();
        chk("t3_done_once", done_cnt, 1);

        // empty range
        start_dump(5'd7, 5'd3);
        bc = 0; vc = 0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            start = 1'b0;
            if (busy0) bc++;
            if (out_valid0) vc++;
        end
        chk("t4_busy_cycles", bc, 1);
        chk("t4_valid_cycles", vc, 0);
        chk("t4_done_once", done_cnt, 1);

        // abort during second hold together with ready
        start_dump(5'd0, 5'd31);
        got = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            start = 1'b0;
            if (out_valid0 && out_index0 == 5'd1) begin got = 1; break; end
        end
        chk("t5_reached", got, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_valid", {31'd0, out_valid0}, 32'd0);
        chk("t5_busy", {31'd0, busy0}, 32'd0);
        chk("t5_beats", u0_beats, 1);
        tick(); tick(); tick();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_u1_no_done", u1_done_cnt, 0);
        start_dump(5'd5, 5'd6);
        run_done(20, 1'b0, n0, n1);
        chk("t5_restart_cycle", n0, 5);
        chk("t5_restart_beats", u0_beats, 2);

        // reset mid-dump with start high
        tick(); tick();
        start_dump(5'd0, 5'd31);
        for (int n = 0; n < 6; n++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_zero("t6");
        exp_idx.delete(); exp_dat.delete();
        done_cnt = 0; u0_beats = 0;
        tick(); tick(); tick();
        chk("t6_still_idle", {31'd0, busy0}, 32'd0);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_no_beats", u0_beats, 0);

        // abort beats start in idle; lone abort in idle is harmless
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("t7_abort_start", {31'd0, busy0}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_abort_idle", {31'd0, busy0}, 32'd0);

        // 0..0: one zero beat normally, none with skip-zero
        start_dump(5'd0, 5'd0);
        run_done(20, 1'b0, n0, n1);
        chk("t8_done_cycle", n0, 3);
        chk("t8_u1_done_cycle", n1, 1);
        chk("t8_beats", u0_beats, 1);
        chk("t8_u1_beats", u1_beats, 0);
        tick(); tick();
        chk("t8_u1_done_once", u1_done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
